// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
// Shares a single AES decryption core between two requesters using
// round-robin arbitration. A job is accepted on a valid/ready handshake.
// The core is pulsed through reset for one cycle and then run until it
// raises its finish flag or the run timeout expires. The result is then
// returned on a valid/ready response port, tagged with the requester ID and
// an error flag.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   reqN_valid/ready    job handshake for requester N (N = 0, 1)
//   reqN_block/key/mux  job payload: ciphertext, key, key-size select
//   eng_reset           core reset (high whenever the core is not running)
//   eng_mux/key/in      core configuration and input state
//   eng_out, eng_finish core result and done flag
//   rsp_valid/ready     response handshake
//   rsp_data/id/err     plaintext (0 on error), requester ID, error flag
//   busy                high in every state except IDLE
//
// States:
//   IDLE  | waiting for a job; core parked in reset
//   CLEAR | one-cycle core reset before a run
//   RUN   | core released; waiting for finish or timeout
//   RESP  | response presented until consumed

module aes_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic [255:0] req0_key,
  input  logic [1:0]   req0_mux,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic [255:0] req1_key,
  input  logic [1:0]   req1_mux,

  output logic         eng_reset,
  output logic [1:0]   eng_mux,
  output logic [255:0] eng_key,
  output logic [127:0] eng_in,
  input  logic [127:0] eng_out,
  input  logic         eng_finish,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,

  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       MUX_ILLEGAL = 2'b11;

  state_t             state_q, state_d;
  logic               rr_ptr_q;
  logic [CNT_W-1:0]   run_cnt_q;

  logic               grant0, grant1;
  logic               accept;
  logic               acc_id;
  logic [127:0]       acc_block;
  logic [255:0]       acc_key;
  logic [1:0]         acc_mux;
  logic               timeout_hit;

  // Arbitration. Grants are only offered in IDLE. On a conflict, rr_ptr
  // picks the winner; otherwise the lone valid requester wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr_q;
        grant1 = rr_ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // A grant is only ever given to a requester that is valid, so a grant
  // is an accept.
  assign accept    = grant0 | grant1;
  assign acc_id    = grant1;
  assign acc_block = grant1 ? req1_block : req0_block;
  assign acc_key   = grant1 ? req1_key   : req0_key;
  assign acc_mux   = grant1 ? req1_mux   : req0_mux;

  assign timeout_hit = (run_cnt_q == CNT_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (acc_mux == MUX_ILLEGAL) ? RESP : CLEAR;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (eng_finish || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // These outputs decode directly from the registered state. The core is
  // held in reset everywhere except RUN.
  assign eng_reset = (state_q != RUN);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      run_cnt_q <= '0;
      eng_mux   <= '0;
      eng_key   <= '0;
      eng_in    <= '0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            eng_in   <= acc_block;
            eng_key  <= acc_key;
            eng_mux  <= acc_mux;
            rsp_id   <= acc_id;
            rr_ptr_q <= ~acc_id;
            rsp_data <= '0;
            // An illegal key size is answered immediately with an error.
            // The core is never released for it.
            rsp_err  <= (acc_mux == MUX_ILLEGAL);
          end
        end
        CLEAR: begin
          run_cnt_q <= '0;
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + CNT_W'(1);
          // If finish and timeout occur together, finish wins.
          if (eng_finish) begin
            rsp_data <= eng_out;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one AES decryption core between two independent requesters (req0, req1).
- Each job carries a 128-bit block, a 256-bit key and a 2-bit key-size select (00=AES-128, 01=AES-192, 10=AES-256, 11=illegal).
- Round-robin arbitration; drives the core's reset/select/key/input lines; waits for the core's finish flag; returns the result on a valid/ready response port tagged with requester ID and error flag.
- Sits between the bus-side request logic and the decryption core.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in RUN before the job is aborted with an error
- CNT_W, 7, width of the run-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle when both valid and ready are 1
- req0_block  in  128  ciphertext, requester 0
- req0_key  in  256  key, requester 0
- req0_mux  in  2  key-size select, requester 0
- req1_valid, req1_ready, req1_block, req1_key, req1_mux  same as above, requester 1
- eng_reset  out  1  reset to the core; active-high
- eng_mux  out  2  key-size select to the core
- eng_key  out  256  key to the core
- eng_in  out  128  input state to the core
- eng_out  in  128  core output state
- eng_finish  in  1  core done flag; level, valid only while eng_reset=0
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  128  plaintext (0 on error)
- rsp_id  out  1  requester that issued the job
- rsp_err  out  1  1 = illegal mux or timeout
- busy  out  1  1 in any state except IDLE

Behaviour:
- States: IDLE, CLEAR, RUN, RESP. State, pointer, counter and all registered outputs update only on posedge clk.
- Reset (sync, priority over everything, including mid-job):
  - state=IDLE, rr_ptr=0 (req0 preferred).
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
  - eng_reset=1, eng_mux=0, eng_key=0, eng_in=0.
  - An in-flight job is dropped with no response.
- Grant (combinational, IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - reqN_ready=1 only for the granted requester in IDLE; 0 in all other states.
- Accept (valid&ready):
  - Latch block/key/mux into eng_in/eng_key/eng_mux; latch ID.
  - rr_ptr <= ~ID (after any grant).
  - mux==11: go straight to RESP with rsp_err=1, rsp_data=0; the engine is not started.
  - Otherwise: go to CLEAR.
- CLEAR: eng_reset=1 for exactly one cycle; counter <= 0; next state RUN.
- RUN:
  - eng_reset=0; counter increments each cycle.
  - eng_finish=1: rsp_data <= eng_out, rsp_err <= 0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - finish and timeout in the same cycle: finish wins.
- RESP:
  - rsp_valid=1; rsp_data/id/err held stable until rsp_valid&rsp_ready; then go to IDLE with rsp_valid=0.
  - eng_reset=1 in RESP and IDLE, so the core is parked.
  - Response latency: at least one cycle; at most one response is outstanding.
- Back-to-back: the earliest next accept is the cycle after the response handshake (IDLE for ≥1 cycle between jobs).
- eng_mux/key/in are stable from CLEAR through end of RUN.
- A requester must hold valid and its payload until its ready handshake; the block latches the payload only at accept.

Test Plan:
- Single AES-128 job on req0: FIPS-197 C.1 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102…0f (upper 128 bits, zero-padded) -> eng_reset high exactly 1 cycle, rsp_valid with rsp_data 00112233445566778899aabbccddeeff, rsp_id=0, rsp_err=0.
- Both requesters valid continuously, 4 jobs -> grants alternate 0,1,0,1; each req sees ready for exactly one cycle per job; rsp_id sequence 0,1,0,1.
- req1 with mux=11 -> RESP the cycle after accept, rsp_err=1, rsp_data=0, eng_reset never deasserted.
- Engine model holds eng_finish=0 -> rsp_err=1 after TIMEOUT_CYCLES (64) RUN cycles, rsp_data=0; then a normal job completes correctly.
- rsp_ready held low 10 cycles -> rsp_valid/data/id/err stable for all 10, no new accept; accept occurs after handshake plus one IDLE cycle.
- reset asserted mid-RUN -> next cycle state IDLE, busy=0, rsp_valid=0, eng_reset=1, rr_ptr=0; no stale response appears.
